// File: rtl/mips_pkg.sv
// ============================================================================
// Module      : mips_pkg
// Description : Shared MIPS decode definitions: opcode constants, the
//               immediate-extension mode and decode-controller state enums,
//               and small per-opcode classification helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;

    typedef enum logic [1:0] {
        EXT_SIGN = 2'd0,
        EXT_ZERO = 2'd1,
        EXT_LUI  = 2'd2
    } ext_mode_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } decode_state_t;

    // Logical immediates are zero-extended, lui shifts, everything else
    // (arithmetic, loads/stores, branch offsets) is sign-extended.
    function automatic ext_mode_t ext_mode_of(input logic [5:0] op);
        ext_mode_t m;
        case (op)
            OP_ANDI, OP_ORI, OP_XORI: m = EXT_ZERO;
            OP_LUI:                   m = EXT_LUI;
            default:                  m = EXT_SIGN;
        endcase
        return m;
    endfunction

    function automatic logic is_reg_write(input logic [5:0] op);
        logic w;
        case (op)
            OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI,
            OP_XORI, OP_LUI, OP_LW:  w = 1'b1;
            default:                 w = 1'b0;
        endcase
        return w;
    endfunction

    // Opcodes that read rt as a source operand (rather than writing it).
    function automatic logic is_rt_src(input logic [5:0] op);
        logic s;
        case (op)
            OP_RTYPE, OP_SW, OP_BEQ, OP_BNE: s = 1'b1;
            default:                         s = 1'b0;
        endcase
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/decode_stage_controller_if.sv
// ============================================================================
// Module      : decode_stage_controller_if
// Description : Bundle between IF/ID, the decode controller and ID/EX.
//               master : fetch/execute side (drives instruction, valid,
//                        branch_taken; observes controls and ID/EX fields)
//               slave  : the decode stage controller
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface decode_stage_controller_if #(
    parameter int CNT_W = 16
);
    logic              instr_valid;
    logic [31:0]       instruction;
    logic              branch_taken;
    logic              pc_write;
    logic              ifid_write;
    logic              idex_valid;
    logic [31:0]       idex_imm;
    logic [4:0]        idex_rs;
    logic [4:0]        idex_rt;
    logic [4:0]        idex_rd;
    logic              idex_mem_read;
    logic              idex_reg_write;
    logic [CNT_W-1:0]  event_count;

    modport master (
        output instr_valid, instruction, branch_taken,
        input  pc_write, ifid_write, idex_valid, idex_imm,
               idex_rs, idex_rt, idex_rd, idex_mem_read,
               idex_reg_write, event_count
    );

    modport slave (
        input  instr_valid, instruction, branch_taken,
        output pc_write, ifid_write, idex_valid, idex_imm,
               idex_rs, idex_rt, idex_rd, idex_mem_read,
               idex_reg_write, event_count
    );
endinterface

`default_nettype wire

// File: rtl/decode_stage_controller_imm_extender.sv
// ============================================================================
// Module      : imm_extender
// Description : Combinational 16->32 bit immediate extension.
//   imm16_i    : raw instruction immediate
//   ext_mode_i : EXT_SIGN / EXT_ZERO / EXT_LUI
//   imm32_o    : extended immediate
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_extender
    import mips_pkg::*;
(
    input  logic [15:0] imm16_i,
    input  ext_mode_t   ext_mode_i,
    output logic [31:0] imm32_o
);

    always_comb begin
        imm32_o = {{16{imm16_i[15]}}, imm16_i};
        case (ext_mode_i)
            EXT_ZERO: imm32_o = {16'h0000, imm16_i};
            EXT_LUI:  imm32_o = {imm16_i, 16'h0000};
            default:  imm32_o = {{16{imm16_i[15]}}, imm16_i};
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/decode_stage_controller.sv
// ============================================================================
// Module      : decode_stage_controller
// Description : MIPS decode-stage sequencing. Decodes the IF/ID word into the
//               registered ID/EX fields, stalls one cycle on a load-use
//               hazard and squashes decode for 1+FLUSH_CYCLES cycles on a
//               taken branch. Counts inserted bubbles (saturating).
//   clk, rst_n : clock, asynchronous active-low reset
//   dec        : slave side of decode_stage_controller_if
//                (instr_valid/instruction/branch_taken in; pc_write,
//                 ifid_write combinational out; idex_* and event_count
//                 registered out)
//   FLUSH_CYCLES (0..7) : bubbles after the branch cycle's own squash
//   CNT_W               : event counter width
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_stage_controller
    import mips_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    decode_stage_controller_if.slave   dec
);

    localparam logic [2:0] c_FC_INIT =
        (FLUSH_CYCLES > 0) ? 3'(FLUSH_CYCLES - 1) : 3'd0;
    localparam logic       c_HAS_FLUSH = (FLUSH_CYCLES > 0);

    // ------------------------------------------------------------------
    // Field decode
    // ------------------------------------------------------------------
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic [31:0] imm_ext;
    ext_mode_t   ext_mode;

    assign op       = dec.instruction[31:26];
    assign rs       = dec.instruction[25:21];
    assign rt       = dec.instruction[20:16];
    assign rd       = dec.instruction[15:11];
    assign imm16    = dec.instruction[15:0];
    assign ext_mode = ext_mode_of(op);

    imm_extender u_imm_extender (
        .imm16_i    (imm16),
        .ext_mode_i (ext_mode),
        .imm32_o    (imm_ext)
    );

    // ------------------------------------------------------------------
    // ID/EX registers
    // ------------------------------------------------------------------
    logic              idex_valid_q, idex_valid_d;
    logic [31:0]       idex_imm_q,   idex_imm_d;
    logic [4:0]        idex_rs_q,    idex_rs_d;
    logic [4:0]        idex_rt_q,    idex_rt_d;
    logic [4:0]        idex_rd_q,    idex_rd_d;
    logic              idex_mem_read_q,  idex_mem_read_d;
    logic              idex_reg_write_q, idex_reg_write_d;
    logic [CNT_W-1:0]  event_count_q, event_count_d;

    // ------------------------------------------------------------------
    // Load-use hazard: the load in ID/EX writes a register the instruction
    // in IF/ID is about to read. r0 never carries a dependency.
    // ------------------------------------------------------------------
    logic hazard;

    assign hazard = dec.instr_valid && idex_valid_q && idex_mem_read_q &&
                    (idex_rt_q != 5'd0) &&
                    ((idex_rt_q == rs) || ((idex_rt_q == rt) && is_rt_src(op)));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    decode_state_t state_q, state_d;
    logic [2:0]    fc_q, fc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            fc_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            fc_q    <= fc_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        fc_d    = fc_q;
        case (state_q)
            RUN: begin
                if (dec.branch_taken) begin
                    if (c_HAS_FLUSH) begin
                        state_d = FLUSH;
                        fc_d    = c_FC_INIT;
                    end else begin
                        state_d = RUN;
                    end
                end else if (hazard) begin
                    state_d = STALL;
                end else begin
                    state_d = RUN;
                end
            end
            STALL: begin
                // The bubble just inserted clears idex_valid, so no second
                // stall is possible here.
                if (dec.branch_taken && c_HAS_FLUSH) begin
                    state_d = FLUSH;
                    fc_d    = c_FC_INIT;
                end else begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                if (dec.branch_taken) begin
                    fc_d = c_FC_INIT;
                end else if (fc_q == 3'd0) begin
                    state_d = RUN;
                end else begin
                    fc_d = fc_q - 3'd1;
                end
            end
            default: begin
                state_d = RUN;
                fc_d    = 3'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Exactly one of load/bubble is asserted every cycle.
    // ------------------------------------------------------------------
    logic load, bubble, advance;

    always_comb begin
        load    = 1'b0;
        bubble  = 1'b0;
        advance = 1'b1;
        case (state_q)
            RUN: begin
                if (dec.branch_taken) begin
                    bubble = 1'b1;
                end else if (hazard) begin
                    bubble  = 1'b1;
                    advance = 1'b0;
                end else begin
                    load = 1'b1;
                end
            end
            STALL: begin
                if (dec.branch_taken) begin
                    bubble = 1'b1;
                end else begin
                    load = 1'b1;
                end
            end
            FLUSH:   bubble = 1'b1;
            default: bubble = 1'b1;
        endcase
    end

    assign dec.pc_write   = advance;
    assign dec.ifid_write = advance;

    // ------------------------------------------------------------------
    // ID/EX next values. A bubble clears only the control bits; the data
    // fields keep their previous contents.
    // ------------------------------------------------------------------
    always_comb begin
        idex_valid_d     = idex_valid_q;
        idex_imm_d       = idex_imm_q;
        idex_rs_d        = idex_rs_q;
        idex_rt_d        = idex_rt_q;
        idex_rd_d        = idex_rd_q;
        idex_mem_read_d  = idex_mem_read_q;
        idex_reg_write_d = idex_reg_write_q;
        event_count_d    = event_count_q;

        if (load) begin
            idex_valid_d     = dec.instr_valid;
            idex_imm_d       = imm_ext;
            idex_rs_d        = rs;
            idex_rt_d        = rt;
            idex_rd_d        = rd;
            // Controls of an invalid word must not leak into EX.
            idex_mem_read_d  = dec.instr_valid && (op == OP_LW);
            idex_reg_write_d = dec.instr_valid && is_reg_write(op);
        end else if (bubble) begin
            idex_valid_d     = 1'b0;
            idex_mem_read_d  = 1'b0;
            idex_reg_write_d = 1'b0;
        end

        if (bubble && (event_count_q != {CNT_W{1'b1}})) begin
            event_count_d = event_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_valid_q     <= 1'b0;
            idex_imm_q       <= 32'h0;
            idex_rs_q        <= 5'd0;
            idex_rt_q        <= 5'd0;
            idex_rd_q        <= 5'd0;
            idex_mem_read_q  <= 1'b0;
            idex_reg_write_q <= 1'b0;
            event_count_q    <= '0;
        end else begin
            idex_valid_q     <= idex_valid_d;
            idex_imm_q       <= idex_imm_d;
            idex_rs_q        <= idex_rs_d;
            idex_rt_q        <= idex_rt_d;
            idex_rd_q        <= idex_rd_d;
            idex_mem_read_q  <= idex_mem_read_d;
            idex_reg_write_q <= idex_reg_write_d;
            event_count_q    <= event_count_d;
        end
    end

    assign dec.idex_valid     = idex_valid_q;
    assign dec.idex_imm       = idex_imm_q;
    assign dec.idex_rs        = idex_rs_q;
    assign dec.idex_rt        = idex_rt_q;
    assign dec.idex_rd        = idex_rd_q;
    assign dec.idex_mem_read  = idex_mem_read_q;
    assign dec.idex_reg_write = idex_reg_write_q;
    assign dec.event_count    = event_count_q;

endmodule

`default_nettype wire

// File: tb/tb_decode_stage_controller.sv
// ============================================================================
// Module      : tb_decode_stage_controller
// Description : Directed self-checking bench for decode_stage_controller
//               (FLUSH_CYCLES=1, CNT_W=8 so saturation is reachable quickly).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_stage_controller;
    import mips_pkg::*;

    localparam int FLUSH_CYCLES = 1;
    localparam int CNT_W        = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    decode_stage_controller_if #(.CNT_W(CNT_W)) dec_if ();

    decode_stage_controller #(
        .FLUSH_CYCLES (FLUSH_CYCLES),
        .CNT_W        (CNT_W)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dec   (dec_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; return 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs_f,
                                          input logic [4:0] rt_f, input logic [15:0] imm);
        return {op, rs_f, rt_f, imm};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] rs_f, input logic [4:0] rt_f,
                                          input logic [4:0] rd_f);
        return {OP_RTYPE, rs_f, rt_f, rd_f, 5'd0, 6'h20};
    endfunction

    task automatic drive(input logic [31:0] ins, input logic bt);
        dec_if.instruction  = ins;
        dec_if.instr_valid  = 1'b1;
        dec_if.branch_taken = bt;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        dec_if.instr_valid  = 1'b0;
        dec_if.instruction  = 32'h0;
        dec_if.branch_taken = 1'b0;
        repeat (2) tick();

        // Reset state
        check_val("rst_valid", 32'(dec_if.idex_valid), 32'd0);
        check_val("rst_imm",   dec_if.idex_imm, 32'h0);
        check_val("rst_cnt",   32'(dec_if.event_count), 32'd0);
        check_val("rst_pcw",   32'(dec_if.pc_write), 32'd1);
        rst_n = 1'b1;

        // Immediate extension
        drive(enc_i(OP_ADDI, 5'd1, 5'd2, 16'hFFF0), 1'b0);
        tick();
        check_val("addi_imm",   dec_if.idex_imm, 32'hFFFF_FFF0);
        check_val("addi_rw",    32'(dec_if.idex_reg_write), 32'd1);
        check_val("addi_valid", 32'(dec_if.idex_valid), 32'd1);
        check_val("addi_mr",    32'(dec_if.idex_mem_read), 32'd0);
        check_val("addi_rs",    32'(dec_if.idex_rs), 32'd1);
        check_val("addi_rt",    32'(dec_if.idex_rt), 32'd2);

        drive(enc_i(OP_ORI, 5'd1, 5'd3, 16'h8001), 1'b0);
        tick();
        check_val("ori_imm", dec_if.idex_imm, 32'h0000_8001);

        drive(enc_i(OP_LUI, 5'd0, 5'd4, 16'h1234), 1'b0);
        tick();
        check_val("lui_imm", dec_if.idex_imm, 32'h1234_0000);

        drive(enc_i(OP_SW, 5'd1, 5'd4, 16'h8000), 1'b0);
        tick();
        check_val("sw_imm", dec_if.idex_imm, 32'hFFFF_8000);
        check_val("sw_rw",  32'(dec_if.idex_reg_write), 32'd0);

        // Load-use stall: lw r5 ; add r6,r5,r7
        drive(enc_i(OP_LW, 5'd1, 5'd5, 16'h0004), 1'b0);
        tick();
        check_val("lw_mr", 32'(dec_if.idex_mem_read), 32'd1);
        check_val("lw_rw", 32'(dec_if.idex_reg_write), 32'd1);
        drive(enc_r(5'd5, 5'd7, 5'd6), 1'b0);
        #1;
        check_val("stall_pcw",  32'(dec_if.pc_write), 32'd0);
        check_val("stall_ifid", 32'(dec_if.ifid_write), 32'd0);
        tick();
        check_val("stall_bubble", 32'(dec_if.idex_valid), 32'd0);
        check_val("stall_cnt",    32'(dec_if.event_count), 32'd1);
        #1;
        check_val("stall_pcw_rel", 32'(dec_if.pc_write), 32'd1);
        tick();
        check_val("add_valid", 32'(dec_if.idex_valid), 32'd1);
        check_val("add_rd",    32'(dec_if.idex_rd), 32'd6);
        check_val("add_rs",    32'(dec_if.idex_rs), 32'd5);
        check_val("add_cnt",   32'(dec_if.event_count), 32'd1);

        // lw r0 then add using r0: no stall
        drive(enc_i(OP_LW, 5'd1, 5'd0, 16'h0000), 1'b0);
        tick();
        drive(enc_r(5'd0, 5'd7, 5'd6), 1'b0);
        #1;
        check_val("r0_pcw", 32'(dec_if.pc_write), 32'd1);
        tick();
        check_val("r0_valid", 32'(dec_if.idex_valid), 32'd1);

        // lw r5 then addi with rt=5 as destination: no stall
        drive(enc_i(OP_LW, 5'd1, 5'd5, 16'h0000), 1'b0);
        tick();
        drive(enc_i(OP_ADDI, 5'd9, 5'd5, 16'h0003), 1'b0);
        #1;
        check_val("rtdst_pcw", 32'(dec_if.pc_write), 32'd1);
        tick();
        check_val("rtdst_valid", 32'(dec_if.idex_valid), 32'd1);
        check_val("rtdst_imm",   dec_if.idex_imm, 32'h0000_0003);
        check_val("rtdst_cnt",   32'(dec_if.event_count), 32'd1);

        // Taken branch: squash + FLUSH_CYCLES bubbles
        drive(enc_i(OP_ADDI, 5'd1, 5'd2, 16'h0011), 1'b1);
        #1;
        check_val("br_pcw", 32'(dec_if.pc_write), 32'd1);
        tick();
        check_val("br_b1_valid", 32'(dec_if.idex_valid), 32'd0);
        check_val("br_b1_cnt",   32'(dec_if.event_count), 32'd2);
        dec_if.branch_taken = 1'b0;
        #1;
        check_val("br_flush_pcw",  32'(dec_if.pc_write), 32'd1);
        check_val("br_flush_ifid", 32'(dec_if.ifid_write), 32'd1);
        tick();
        check_val("br_b2_valid", 32'(dec_if.idex_valid), 32'd0);
        check_val("br_b2_cnt",   32'(dec_if.event_count), 32'd3);
        tick();
        check_val("br_resume_valid", 32'(dec_if.idex_valid), 32'd1);
        check_val("br_resume_imm",   dec_if.idex_imm, 32'h0000_0011);
        check_val("br_resume_cnt",   32'(dec_if.event_count), 32'd3);

        // Branch together with hazard: flush wins, no stall cycle
        drive(enc_i(OP_LW, 5'd1, 5'd5, 16'h0000), 1'b0);
        tick();
        drive(enc_r(5'd5, 5'd7, 5'd6), 1'b1);
        #1;
        check_val("brhz_pcw", 32'(dec_if.pc_write), 32'd1);
        tick();
        check_val("brhz_b1_valid", 32'(dec_if.idex_valid), 32'd0);
        check_val("brhz_b1_cnt",   32'(dec_if.event_count), 32'd4);
        dec_if.branch_taken = 1'b0;
        #1;
        check_val("brhz_flush_pcw", 32'(dec_if.pc_write), 32'd1);
        tick();
        check_val("brhz_b2_valid", 32'(dec_if.idex_valid), 32'd0);
        check_val("brhz_b2_cnt",   32'(dec_if.event_count), 32'd5);
        tick();
        check_val("brhz_resume_valid", 32'(dec_if.idex_valid), 32'd1);
        check_val("brhz_resume_rd",    32'(dec_if.idex_rd), 32'd6);

        // Reset while in STALL
        drive(enc_i(OP_LW, 5'd1, 5'd5, 16'h0000), 1'b0);
        tick();
        drive(enc_r(5'd5, 5'd7, 5'd6), 1'b0);
        tick();
        check_val("pre_rst_cnt", 32'(dec_if.event_count), 32'd6);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_valid", 32'(dec_if.idex_valid), 32'd0);
        check_val("mid_rst_imm",   dec_if.idex_imm, 32'h0);
        check_val("mid_rst_rd",    32'(dec_if.idex_rd), 32'd0);
        check_val("mid_rst_rw",    32'(dec_if.idex_reg_write), 32'd0);
        check_val("mid_rst_cnt",   32'(dec_if.event_count), 32'd0);
        rst_n = 1'b1;
        #1;
        check_val("post_rst_pcw", 32'(dec_if.pc_write), 32'd1);
        tick();
        check_val("post_rst_valid", 32'(dec_if.idex_valid), 32'd1);
        check_val("post_rst_rd",    32'(dec_if.idex_rd), 32'd6);
        check_val("post_rst_cnt",   32'(dec_if.event_count), 32'd0);

        // Saturation: 2^CNT_W + 3 consecutive bubbles
        dec_if.branch_taken = 1'b1;
        repeat ((1 << CNT_W) + 3) tick();
        check_val("sat_cnt",   32'(dec_if.event_count), 32'((1 << CNT_W) - 1));
        check_val("sat_valid", 32'(dec_if.idex_valid), 32'd0);
        dec_if.branch_taken = 1'b0;
        repeat (3) tick();
        check_val("sat_hold_cnt", 32'(dec_if.event_count), 32'((1 << CNT_W) - 1));
        check_val("sat_resume_valid", 32'(dec_if.idex_valid), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/decode_stage_controller.md
Name: decode_stage_controller

Overview:
- Sequencing controller for the MIPS decode stage.
- Chooses the immediate-extension mode per opcode (sign, zero, LUI shift) and drives the registered ID/EX immediate.
- Detects load-use hazards and squashes decode on taken branches, using a small FSM.
- Sits between the IF/ID register and the EX stage. Owns pc_write/ifid_write and the ID/EX control fields.

Parameters:
- FLUSH_CYCLES, 1: bubbles inserted after branch_taken, on top of the squash in the branch cycle itself; legal range 0..7.
- CNT_W, 16: width of the saturating stall/flush event counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- instr_valid  in  1  IF/ID holds a valid instruction
- instruction  in  32  IF/ID instruction word
- branch_taken  in  1  EX resolved a taken branch this cycle
- pc_write  out  1  PC may advance (combinational)
- ifid_write  out  1  IF/ID may load (combinational)
- idex_valid  out  1  ID/EX holds a real instruction (0 = bubble)
- idex_imm  out  32  extended immediate
- idex_rs, idex_rt, idex_rd  out  5 each  register fields
- idex_mem_read  out  1  ID/EX instruction is lw
- idex_reg_write  out  1  ID/EX instruction writes the register file
- event_count  out  CNT_W  saturating count of bubbles inserted

Behaviour:
- Reset (async, rst_n=0):
  - All registered outputs go to 0 and the FSM goes to RUN.
  - A reset mid-stall or mid-flush abandons the sequence with no residual bubble.
- Field decode:
  - op=instr[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0].
- Extension:
  - op 0x0C/0x0D/0x0E (andi/ori/xori): zero-extend, {16'h0, imm}.
  - op 0x0F (lui): {imm, 16'h0}.
  - All other opcodes: sign-extend, {16{imm[15]}, imm}.
- Control:
  - mem_read=1 only for op 0x23.
  - reg_write=1 for op 0x00, 0x08, 0x0C–0x0F, 0x23.
  - reg_write=0 for 0x2B, 0x04, 0x05 and all unlisted opcodes.
- rt-as-source: op 0x00, 0x2B, 0x04, 0x05.
- hazard, combinational, all terms ANDed:
  - instr_valid
  - idex_valid
  - idex_mem_read
  - idex_rt != 0
  - idex_rt == rs, OR (idex_rt == rt AND rt-as-source)
- FSM states: RUN, STALL, FLUSH; flush counter fc is 3 bits.
- RUN:
  - branch_taken has priority over hazard: bubble into ID/EX; pc_write=ifid_write=1; if FLUSH_CYCLES>0, fc<=FLUSH_CYCLES-1 and go to FLUSH, else stay in RUN.
  - Else if hazard: bubble; pc_write=ifid_write=0; go to STALL.
  - Else: load ID/EX with decoded fields; idex_valid<=instr_valid; pc_write=ifid_write=1.
- STALL:
  - Lasts exactly one cycle; the bubble guarantees no hazard.
  - Loads the held instruction normally and returns to RUN.
  - branch_taken in STALL: bubble instead, then behave as from RUN on branch_taken.
- FLUSH:
  - Bubble every cycle; pc_write=ifid_write=1.
  - fc==0 -> RUN, else fc<=fc-1.
  - branch_taken during FLUSH reloads fc<=FLUSH_CYCLES-1.
- Bubble definition: idex_valid, idex_mem_read and idex_reg_write cleared. idex_imm/rs/rt/rd are don't-care but held at their previous values.
- event_count increments on every bubble cycle and saturates at all-ones without wrapping.
- Latency: ID/EX outputs update one cycle after the IF/ID instruction is presented.
- pc_write/ifid_write are combinational from current state and inputs.

Decomposition:
- Shared package mips_pkg:
  - opcode constants OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_LW, OP_SW, OP_BEQ, OP_BNE
  - ext_mode_t enum {EXT_SIGN, EXT_ZERO, EXT_LUI}
  - decode_state_t enum {RUN, STALL, FLUSH}
- One sub-module: imm_extender, a combinational (imm16, ext_mode) -> imm32 unit. It supersedes the plain sign extender in decode.

Test Plan:
- addi with imm 0xFFF0 -> idex_imm=0xFFFFFFF0 next cycle; idex_reg_write=1.
- ori with imm 0x8001 -> 0x00008001. lui with imm 0x1234 -> 0x12340000.
- lw r5 then add r6,r5,r7 back-to-back -> one cycle with pc_write=ifid_write=0. Then a bubble (idex_valid=0), then the add issues; event_count=1.
- lw r0 then add using r0 -> no stall. lw r5 then addi r8,r9 (rt is dest) -> no stall.
- branch_taken with FLUSH_CYCLES=1 -> 2 consecutive bubbles, pc_write stays 1, event_count +2. branch_taken together with a hazard -> flush wins with no stall cycle.
- rst_n low in STALL -> all outputs 0 immediately; after release, the first valid instruction issues normally. Drive 2^CNT_W+3 bubbles -> event_count stays at all-ones.
